// File: rtl/info_record_cache.sv
// info_record_cache
// Direct-mapped cache of packed user/shop records, keyed by user ID, placed
// between the shopping controller record port and the DRAM bridge.
// Build option: define INFO_CACHE_WB_EN for write-back with dirty lines.
// Without it the cache is write-through: every write is forwarded to the
// bridge immediately, and lines are always clean.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for a request or a flush command
// S_EVICT     | bridge write in flight (dirty victim, or write-through write)
// S_FILL_REQ  | fetch request presented to the bridge
// S_FILL_WAIT | fetch accepted, waiting for mem_rsp_valid
// S_RESP      | rsp_valid pulse to the controller
// S_FLUSH     | scanning all lines, writing back dirty ones

module info_record_cache #(
   parameter int ENTRIES = 4,
   parameter int ID_W    = 8,
   parameter int REC_W   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [ID_W-1:0]  req_id,
   input  logic [REC_W-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [REC_W-1:0] rsp_data,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_req_write,
   output logic [ID_W-1:0]  mem_req_addr,
   output logic [REC_W-1:0] mem_req_wdata,
   input  logic             mem_rsp_valid,
   input  logic [REC_W-1:0] mem_rsp_data,
   input  logic             flush,
   output logic             flush_done,
   output logic [15:0]      hit_cnt,
   output logic [15:0]      miss_cnt
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EVICT,
      S_FILL_REQ,
      S_FILL_WAIT,
      S_RESP,
      S_FLUSH
   } state_t;

   state_t             state;
   logic [ENTRIES-1:0] line_valid;
   logic [ID_W-1:0]    line_tag  [ENTRIES];
   logic [REC_W-1:0]   line_data [ENTRIES];
`ifdef INFO_CACHE_WB_EN
   logic [ENTRIES-1:0] line_dirty;
   logic               cur_write;
   logic [REC_W-1:0]   cur_wdata;
`endif
   logic [IDX_W-1:0]   cur_idx;
   logic [ID_W-1:0]    cur_id;
   logic [IDX_W-1:0]   flush_idx;

   logic [IDX_W-1:0]   req_idx;
   logic               req_hit;
   logic               victim_dirty;
   logic               flush_wb;
   logic               flush_last;

   // Request acceptance, line lookup and flush scan decode
   assign req_ready  = rst_n && (state == S_IDLE) && !flush;
   assign req_idx    = req_id[IDX_W-1:0];
   assign req_hit    = line_valid[req_idx] && (line_tag[req_idx] == req_id);
   assign flush_last = (flush_idx == LAST_IDX);
`ifdef INFO_CACHE_WB_EN
   assign victim_dirty = line_valid[req_idx] && line_dirty[req_idx];
   assign flush_wb     = line_valid[flush_idx] && line_dirty[flush_idx];
`else
   assign victim_dirty = 1'b0;
   assign flush_wb     = 1'b0;
`endif

   // Controller FSM, line storage, bridge port and statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         line_valid    <= '0;
`ifdef INFO_CACHE_WB_EN
         line_dirty    <= '0;
         cur_write     <= 1'b0;
         cur_wdata     <= '0;
`endif
         for (int i = 0; i < ENTRIES; i++) begin
            line_tag[i]  <= '0;
            line_data[i] <= '0;
         end
         cur_idx       <= '0;
         cur_id        <= '0;
         flush_idx     <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         flush_done    <= 1'b0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
      end else begin
         rsp_valid  <= 1'b0;
         flush_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (flush) begin
                  flush_idx <= '0;
                  state     <= S_FLUSH;
               end else if (req_valid) begin
                  cur_idx <= req_idx;
                  cur_id  <= req_id;
`ifdef INFO_CACHE_WB_EN
                  cur_write <= req_write;
                  cur_wdata <= req_wdata;
`endif
                  if (req_hit) begin
                     if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                     if (req_write) begin
                        line_data[req_idx] <= req_wdata;
                        rsp_data           <= req_wdata;
`ifdef INFO_CACHE_WB_EN
                        line_dirty[req_idx] <= 1'b1;
                        rsp_valid           <= 1'b1;
                        state               <= S_RESP;
`else
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= req_id;
                        mem_req_wdata <= req_wdata;
                        state         <= S_EVICT;
`endif
                     end else begin
                        rsp_data  <= line_data[req_idx];
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                     end
                  end else begin
                     if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                     if (victim_dirty) begin
                        // write-back of the old owner comes before anything else
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= line_tag[req_idx];
                        mem_req_wdata <= line_data[req_idx];
                        state         <= S_EVICT;
                     end else if (req_write) begin
                        line_valid[req_idx] <= 1'b1;
                        line_tag[req_idx]   <= req_id;
                        line_data[req_idx]  <= req_wdata;
                        rsp_data            <= req_wdata;
`ifdef INFO_CACHE_WB_EN
                        line_dirty[req_idx] <= 1'b1;
                        rsp_valid           <= 1'b1;
                        state               <= S_RESP;
`else
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= req_id;
                        mem_req_wdata <= req_wdata;
                        state         <= S_EVICT;
`endif
                     end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= req_id;
                        mem_req_wdata <= '0;
                        state         <= S_FILL_REQ;
                     end
                  end
               end
            end

            S_EVICT: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
`ifdef INFO_CACHE_WB_EN
                  line_dirty[cur_idx] <= 1'b0;
                  if (cur_write) begin
                     line_valid[cur_idx] <= 1'b1;
                     line_dirty[cur_idx] <= 1'b1;
                     line_tag[cur_idx]   <= cur_id;
                     line_data[cur_idx]  <= cur_wdata;
                     rsp_data            <= cur_wdata;
                     rsp_valid           <= 1'b1;
                     state               <= S_RESP;
                  end else begin
                     // fetch is a new transaction and follows directly
                     mem_req_valid <= 1'b1;
                     mem_req_write <= 1'b0;
                     mem_req_addr  <= cur_id;
                     mem_req_wdata <= '0;
                     state         <= S_FILL_REQ;
                  end
`else
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
`endif
               end
            end

            S_FILL_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= S_FILL_WAIT;
               end
            end

            S_FILL_WAIT: begin
               if (mem_rsp_valid) begin
                  line_valid[cur_idx] <= 1'b1;
                  line_tag[cur_idx]   <= cur_id;
                  line_data[cur_idx]  <= mem_rsp_data;
`ifdef INFO_CACHE_WB_EN
                  line_dirty[cur_idx] <= 1'b0;
`endif
                  rsp_data  <= mem_rsp_data;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end
            end

            S_RESP: begin
               state <= S_IDLE;
            end

            S_FLUSH: begin
               if (mem_req_valid && !mem_req_ready) begin
                  state <= S_FLUSH;
               end else if (!mem_req_valid && flush_wb) begin
                  mem_req_valid <= 1'b1;
                  mem_req_write <= 1'b1;
                  mem_req_addr  <= line_tag[flush_idx];
                  mem_req_wdata <= line_data[flush_idx];
               end else begin
                  if (mem_req_valid) begin
                     mem_req_valid <= 1'b0;
`ifdef INFO_CACHE_WB_EN
                     line_dirty[flush_idx] <= 1'b0;
`endif
                  end
                  if (flush_last) begin
                     flush_done <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     flush_idx <= flush_idx + 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/info_record_cache.md
# info_record_cache

Parametrised direct-mapped cache for the packed 64-bit user/shop records exchanged between the online-shopping controller and the DRAM bridge. Records are keyed by user ID. Read misses are filled from the bridge. Dirty lines are written back on eviction or on a flush command. The block sits between the controller's record port and the bridge's AXI-lite-facing request port, cutting bridge traffic for repeated IDs.

## Interface
- `ENTRIES`, 4: number of lines; power of two, 2..64; index = `req_id[$clog2(ENTRIES)-1:0]`.
- `ID_W`, 8: user-ID width; the full ID is stored as the tag.
- `REC_W`, 64: record width (shop info 32 + user info 32).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: controller request.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = full-record write, 0 = read.
- `req_id` in ID_W: user ID.
- `req_wdata` in REC_W: write record.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_data` out REC_W: read record, or the written record echoed back.
- `mem_req_valid` out 1: bridge request.
- `mem_req_ready` in 1: bridge accept.
- `mem_req_write` out 1: 1 = write-back, 0 = fetch.
- `mem_req_addr` out ID_W: user ID.
- `mem_req_wdata` out REC_W: write-back data.
- `mem_rsp_valid` in 1: fetch data valid.
- `mem_rsp_data` in REC_W: fetched record.
- `flush` in 1: single-cycle flush command pulse.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `hit_cnt` out 16: saturating hit counter.
- `miss_cnt` out 16: saturating miss counter.

## Operation
- States: IDLE, EVICT, FILL_REQ, FILL_WAIT, RESP, FLUSH.
- `req_ready = rst_n && state==IDLE && !flush`. When `flush` and `req_valid` coincide, the flush wins.
- Hit (valid && tag==req_id):
  - Read: `rsp_data` = line.
  - Write: line ← wdata, dirty ← 1.
  - `hit_cnt`++. Goes to RESP.
- Miss: `miss_cnt`++.
  - If the victim is valid and dirty: EVICT. Issues a write of the victim tag/data, then clears dirty.
  - Next step for a read: FILL_REQ → FILL_WAIT. On `mem_rsp_valid`, install the line clean (valid=1, tag=req_id) → RESP.
  - Next step for a write: install wdata dirty (no fetch) → RESP.
- RESP: `rsp_valid`=1 for one cycle → IDLE.
- FLUSH: scan index 0..ENTRIES-1, one index per cycle unless a write-back is pending.
  - Each valid+dirty line is written back and its dirty bit cleared. Lines stay valid.
  - `flush_done` pulses the cycle after the last index completes → IDLE.
  - `flush` asserted outside IDLE is ignored.
- Counters saturate at 16'hFFFF and never wrap.
- Reset, asynchronous, any state:
  - All valid/dirty bits cleared; state IDLE; counters 0.
  - All outputs 0, including `req_ready`, `rsp_data` and `mem_req_*`.
  - An in-flight bridge transaction is abandoned. A `mem_rsp_valid` arriving after reset is ignored.

## Timing
- Request accepted at cycle T.
- Read/write hit: `rsp_valid` at T+1.
- Clean read miss: `mem_req_valid` from T+1. Data arrives at cycle R; `rsp_valid` at R+1.
- Write miss, clean victim: `rsp_valid` at T+1.
- Dirty-victim miss: EVICT starts at T+1. The fill request starts the cycle after the eviction handshake.
- Bridge handshake: `mem_req_valid` and all `mem_req_*` fields are held stable until `mem_req_ready`. `mem_req_valid` drops the cycle after the handshake.
- `mem_rsp_valid` is sampled only in FILL_WAIT and ignored elsewhere.
- Flush with no dirty lines: `flush_done` at T+ENTRIES+1.

## Configuration
- `INFO_CACHE_WB_EN` defined: write-back behaviour as described above.
- Not defined: write-through.
  - No dirty bits.
  - Every write (hit or miss) updates or installs the line clean, then issues a bridge write in the EVICT state carrying req_id/wdata. RESP follows the handshake.
  - Read misses never evict.
  - FLUSH still scans all indices but issues no writes.

## Test plan
- Reset, read `8'h05` (miss): `mem_req` read, addr 05; bridge returns 64'hA5A5_0000_1234_5678 → `rsp_data` equal to that value, `miss_cnt`=1. Read `8'h05` again → `rsp_valid` at T+1, `hit_cnt`=1, no bridge request.
- Write `8'h05` data 64'h1 (hit), then read `8'h09` (same index, ENTRIES=4) → write-back addr 05 data 64'h1, then fetch addr 09 (WB build). Without the macro, the write-back occurs at write time instead.
- Hold `mem_req_ready`=0 for 5 cycles during a fetch → `mem_req_*` stay stable, `req_ready`=0 throughout.
- Dirty lines at indices 1 and 3, pulse `flush` → exactly two bridge writes in index order, then `flush_done`; subsequent reads of those IDs hit.
- Assert `rst_n`=0 in FILL_WAIT, release, then drive `mem_rsp_valid` → ignored; all outputs 0 during reset; next read of the same ID misses.
- Preload `hit_cnt` to 16'hFFFF via repeated hits → the count stays at 16'hFFFF.
